// File: rtl/cnn_window_gen.sv
// Streaming window generator: two line buffers plus a 3x3 shift register build 3x3 windows,
// or pass single pixels in 1x1 mode. Optional `CNN_WIN_CNT_EN adds the o_win_count output.
module cnn_window_gen #(
  parameter int W_SIZE    = 12,
  parameter int MAX_WIDTH = 256
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_data_run,
  input  logic              i_end_frame,
  input  logic [W_SIZE-1:0] i_row,
  input  logic [W_SIZE-1:0] i_col,
  input  logic [W_SIZE-1:0] i_width,
  input  logic [W_SIZE-1:0] i_height,
  input  logic              i_is_conv3x3,
  input  logic [7:0]        i_pixel,
  output logic              o_win_valid,
  output logic [71:0]       o_win,
  output logic [W_SIZE-1:0] o_win_row,
  output logic [W_SIZE-1:0] o_win_col,
`ifdef CNN_WIN_CNT_EN
  output logic [2*W_SIZE:0] o_win_count,
`endif
  output logic              o_frame_done
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [W_SIZE:0] MAXW_L = (W_SIZE + 1)'(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic              mode_q, mode_d;
  logic [7:0]        lb0_q [MAX_WIDTH];
  logic [7:0]        lb1_q [MAX_WIDTH];
  logic [71:0]       sr_q, sr_d;
  logic              valid_q, valid_d;
  logic [71:0]       owin_q, owin_d;
  logic [W_SIZE-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic              done_q;

  logic          pix_s, in_range_s, start_s, last_s, fill_done_s, in_frame_s, mode_eff_s, win_go_s;
  logic [AW-1:0] lb_idx_s;
  logic [7:0]    lb0_rd_s, lb1_rd_s;

  assign pix_s       = i_data_run && !i_end_frame;
  assign in_range_s  = ({1'b0, i_col} < MAXW_L);
  assign lb_idx_s    = i_col[AW-1:0];
  assign lb0_rd_s    = in_range_s ? lb0_q[lb_idx_s] : 8'd0;
  assign lb1_rd_s    = in_range_s ? lb1_q[lb_idx_s] : 8'd0;
  // DONE swallows a row0/col0 pixel: the frame after it starts only from IDLE.
  assign start_s     = pix_s && (i_row == {W_SIZE{1'b0}}) && (i_col == {W_SIZE{1'b0}}) && (state_q != DONE);
  assign last_s      = pix_s && (i_row == i_height - W_SIZE'(1)) && (i_col == i_width - W_SIZE'(1));
  assign fill_done_s = pix_s && (i_row == W_SIZE'(2)) && (i_col == {W_SIZE{1'b0}});
  assign in_frame_s  = start_s || (state_q == FILL) || (state_q == ACTIVE);
  assign mode_eff_s  = start_s ? i_is_conv3x3 : mode_q;
  assign win_go_s    = pix_s && in_range_s && in_frame_s &&
                       (mode_eff_s ? ((i_row >= W_SIZE'(2)) && (i_col >= W_SIZE'(2))) : 1'b1);

  // Frame sequencing and mode latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE, FILL, ACTIVE: begin
        if (start_s) begin
          mode_d = i_is_conv3x3;
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = i_is_conv3x3 ? FILL : ACTIVE;
          end
        end else if (state_q == IDLE) begin
          state_d = IDLE;
        end else if (last_s) begin
          state_d = DONE;
        end else if ((state_q == FILL) && fill_done_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register advance and next window outputs.
  always_comb begin
    sr_d    = sr_q;
    valid_d = 1'b0;
    owin_d  = owin_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    if (pix_s) begin
      sr_d = {i_pixel, sr_q[71:64], sr_q[63:56],
              lb0_rd_s, sr_q[47:40], sr_q[39:32],
              lb1_rd_s, sr_q[23:16], sr_q[15:8]};
    end else begin
      sr_d = sr_q;
    end
    if (win_go_s) begin
      valid_d = 1'b1;
      if (mode_eff_s) begin
        owin_d = sr_d;
        orow_d = i_row - W_SIZE'(2);
        ocol_d = i_col - W_SIZE'(2);
      end else begin
        owin_d = {i_pixel, 64'd0};
        orow_d = i_row;
        ocol_d = i_col;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Line buffers: contents need no reset.
  always_ff @(posedge clk) begin
    if (pix_s && in_range_s) begin
      lb1_q[lb_idx_s] <= lb0_q[lb_idx_s];
      lb0_q[lb_idx_s] <= i_pixel;
    end
  end

  // Control, shift register and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      sr_q    <= 72'd0;
      valid_q <= 1'b0;
      owin_q  <= 72'd0;
      orow_q  <= {W_SIZE{1'b0}};
      ocol_q  <= {W_SIZE{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
      owin_q  <= owin_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign o_win_valid  = valid_q;
  assign o_win        = owin_q;
  assign o_win_row    = orow_q;
  assign o_win_col    = ocol_q;
  assign o_frame_done = done_q;

`ifdef CNN_WIN_CNT_EN
  logic [2*W_SIZE:0] cnt_q, cnt_d;

  // Per-frame window count.
  always_comb begin
    cnt_d = cnt_q;
    if (start_s) begin
      cnt_d = {(2*W_SIZE+1){1'b0}};
    end else if (valid_q) begin
      cnt_d = cnt_q + (2*W_SIZE+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {(2*W_SIZE+1){1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_win_count = cnt_q;
`endif

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: an image-level model predicts windows and frame-done pulses.
module tb_cnn_window_gen;
  localparam int WS = 12;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_data_run = 1'b0, i_end_frame = 1'b0, i_is_conv3x3 = 1'b0;
  logic [WS-1:0] i_row = '0, i_col = '0, i_width = '0, i_height = '0;
  logic [7:0]    i_pixel = 8'd0;
  logic          o_win_valid, o_frame_done;
  logic [71:0]   o_win;
  logic [WS-1:0] o_win_row, o_win_col;
`ifdef CNN_WIN_CNT_EN
  logic [2*WS:0] o_win_count;
`endif

  cnn_window_gen #(.W_SIZE(WS), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rstn(rstn), .i_data_run(i_data_run), .i_end_frame(i_end_frame),
    .i_row(i_row), .i_col(i_col), .i_width(i_width), .i_height(i_height),
    .i_is_conv3x3(i_is_conv3x3), .i_pixel(i_pixel),
    .o_win_valid(o_win_valid), .o_win(o_win), .o_win_row(o_win_row), .o_win_col(o_win_col),
`ifdef CNN_WIN_CNT_EN
    .o_win_count(o_win_count),
`endif
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    int          at;
  } exp_t;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   n_win_seen = 0, n_done_seen = 0;
  exp_t win_q[$];
  int   done_q[$];
  logic [7:0] img [16][16];
  logic [7:0] src [16][16];
  bit   m_in_frame = 1'b0, m_conv = 1'b0;
  int   m_w = 0, m_h = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic set_frame(input int w, input int h, input bit conv);
    m_w = w; m_h = h;
    i_width = WS'(w); i_height = WS'(h); i_is_conv3x3 = conv;
  endtask

  task automatic idle(input int n);
    i_data_run = 1'b0; i_end_frame = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic end_frame_cycle();
    i_data_run = 1'b1; i_end_frame = 1'b1; i_row = '0; i_col = '0; i_pixel = 8'($urandom);
    @(posedge clk);
    #1;
    i_data_run = 1'b0; i_end_frame = 1'b0;
  endtask

  // Model: windows are read straight out of the image array by coordinate.
  task automatic drive_pix(input int r, input int c, input logic [7:0] p);
    exp_t e;
    i_data_run = 1'b1; i_end_frame = 1'b0; i_row = WS'(r); i_col = WS'(c); i_pixel = p;
    if (r == 0 && c == 0) begin
      m_in_frame = 1'b1;
      m_conv = i_is_conv3x3;
    end
    img[r][c] = p;
    if (m_in_frame && c < MW) begin
      e.at = cyc + 1;
      if (!m_conv) begin
        e.win = {p, 64'd0}; e.row = r; e.col = c;
        win_q.push_back(e);
      end else if (r >= 2 && c >= 2) begin
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            e.win[8*(3*dy+dx) +: 8] = img[r-2+dy][c-2+dx];
        e.row = r - 2; e.col = c - 2;
        win_q.push_back(e);
      end
    end
    if (m_in_frame && r == m_h - 1 && c == m_w - 1) begin
      m_in_frame = 1'b0;
      done_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_src(input bit ramp, input int w);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        src[r][c] = ramp ? 8'(r * w + c) : 8'($urandom);
  endtask

  task automatic run_frame(input int w, input int h, input bit conv, input bit gap);
    set_frame(w, h, conv);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        drive_pix(r, c, src[r][c]);
        if (gap && r == 2 && c == 1) end_frame_cycle();
      end
      if (gap) idle(3);
    end
    idle(3);
  endtask

  task automatic check_counts(input string name, input int w0, input int d0, input int ew, input int ed);
    check({name, "_windows"}, n_win_seen - w0, ew);
    check({name, "_done"}, n_done_seen - d0, ed);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a window or a frame-done pulse.
  logic [71:0]   last_win = '0;
  logic [WS-1:0] last_row = '0, last_col = '0;
  exp_t          me;
  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_valid", o_win_valid, 0);
      check("reset_win_nonzero", (o_win != 72'd0) || (o_win_row != '0) || (o_win_col != '0), 0);
      check("reset_done", o_frame_done, 0);
      last_win = '0; last_row = '0; last_col = '0;
    end else begin
      while (win_q.size() > 0 && win_q[0].at < cyc) begin
        me = win_q.pop_front();
        check("missing_window_row_col", me.row * 1000 + me.col, -1);
      end
      if (o_win_valid) begin
        n_win_seen++;
        if (win_q.size() == 0) begin
          check("unexpected_window_row_col", o_win_row * 1000 + o_win_col, -1);
        end else begin
          me = win_q.pop_front();
          n_tests++;
          if (o_win !== me.win || o_win_row !== WS'(me.row) || o_win_col !== WS'(me.col) || cyc != me.at) begin
            n_fail++;
            $display("FAIL window: got win=%h (%0d,%0d) cyc %0d, expected win=%h (%0d,%0d) cyc %0d",
                     o_win, o_win_row, o_win_col, cyc, me.win, me.row, me.col, me.at);
          end
        end
        last_win = o_win; last_row = o_win_row; last_col = o_win_col;
      end else begin
        check("hold_outputs", (o_win !== last_win) || (o_win_row !== last_row) || (o_win_col !== last_col), 0);
      end
      if (o_frame_done) begin
        n_done_seen++;
        if (done_q.size() == 0) check("unexpected_frame_done_cyc", cyc, -1);
        else check("frame_done_cyc", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        check("missing_frame_done_cyc", -1, done_q.pop_front());
      end
    end
  end

  int w0, d0, rw, rh, ew;
  bit rc;
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    // 4x4 ramp frame in 3x3 mode
    w0 = n_win_seen; d0 = n_done_seen;
    fill_src(1'b1, 4);
    run_frame(4, 4, 1'b1, 1'b0);
    check_counts("conv4x4", w0, d0, 4, 1);

    // 1x1 pass mode, 3x2
    w0 = n_win_seen; d0 = n_done_seen;
    fill_src(1'b0, 0);
    run_frame(3, 2, 1'b0, 1'b0);
    check_counts("pass3x2", w0, d0, 6, 1);

    // 5x5 gapless then the same pixels with hsync gaps and an end-frame cycle
    fill_src(1'b0, 0);
    w0 = n_win_seen; d0 = n_done_seen;
    run_frame(5, 5, 1'b1, 1'b0);
    check_counts("conv5x5", w0, d0, 9, 1);
    w0 = n_win_seen; d0 = n_done_seen;
    run_frame(5, 5, 1'b1, 1'b1);
    check_counts("conv5x5_gaps", w0, d0, 9, 1);

    // degenerate 2x5 frame
    w0 = n_win_seen; d0 = n_done_seen;
    run_frame(2, 5, 1'b1, 1'b0);
    check_counts("degen2x5", w0, d0, 0, 1);

    // frame wider than the line buffer
    w0 = n_win_seen; d0 = n_done_seen;
    fill_src(1'b0, 0);
    run_frame(10, 4, 1'b1, 1'b0);
    check_counts("wide10x4", w0, d0, (MW - 2) * 2, 1);

    // restart mid-frame into 1x1 mode
    w0 = n_win_seen; d0 = n_done_seen;
    set_frame(5, 5, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) drive_pix(r, c, 8'($urandom));
    run_frame(3, 2, 1'b0, 1'b0);
    check_counts("restart", w0, d0, 3 + 6, 1);

    // reset in row 2, stray pixels after reset, then a full frame
    w0 = n_win_seen; d0 = n_done_seen;
    fill_src(1'b0, 0);
    set_frame(4, 4, 1'b1);
    for (int c = 0; c < 4; c++) drive_pix(0, c, src[0][c]);
    for (int c = 0; c < 4; c++) drive_pix(1, c, src[1][c]);
    for (int c = 0; c < 3; c++) drive_pix(2, c, src[2][c]);
    idle(2);
    rstn = 1'b0; m_in_frame = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(1);
    drive_pix(2, 3, 8'($urandom));
    for (int c = 0; c < 4; c++) drive_pix(3, c, 8'($urandom));
    idle(3);
    run_frame(4, 4, 1'b1, 1'b0);
    check_counts("after_reset", w0, d0, 1 + 4, 1);

    // random frames
    for (int k = 0; k < 5; k++) begin
      rw = $urandom_range(8, 1); rh = $urandom_range(6, 1); rc = 1'($urandom);
      ew = rc ? ((rw >= 3 && rh >= 3) ? (rw - 2) * (rh - 2) : 0) : rw * rh;
      w0 = n_win_seen; d0 = n_done_seen;
      fill_src(1'b0, 0);
      run_frame(rw, rh, rc, 1'($urandom));
      check_counts("random", w0, d0, ew, 1);
    end

`ifdef CNN_WIN_CNT_EN
    fill_src(1'b0, 0);
    run_frame(6, 6, 1'b1, 1'b0);
    check("win_count_6x6", o_win_count, 16);
    set_frame(4, 4, 1'b1);
    drive_pix(0, 0, 8'd1);
    check("win_count_cleared", o_win_count, 0);
    m_in_frame = 1'b0;
    idle(2);
`endif

    idle(4);
    check("leftover_windows", win_q.size(), 0);
    check("leftover_done", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/cnn_window_gen.md
CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 Parameter W_SIZE, default 12, row/col/size width; matches the upstream frame sequencer.
REQ-002 Parameter MAX_WIDTH, default 256, line-buffer depth in pixels.
REQ-003 clk  input  1  clock, rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_data_run  input  1  upstream data phase; together with i_end_frame=0 it marks a pixel cycle.
REQ-006 i_end_frame  input  1  upstream end-of-frame; a cycle with i_end_frame=1 carries no pixel.
REQ-007 i_row, i_col  input  W_SIZE each  coordinates of the current pixel.
REQ-008 i_width, i_height  input  W_SIZE each  frame size.
REQ-009 i_is_conv3x3  input  1  1 = 3x3 window mode, 0 = 1x1 pass mode.
REQ-010 i_pixel  input  8  pixel value, valid on pixel cycles.
REQ-011 o_win_valid  output  1  window valid strobe.
REQ-012 o_win  output  72  window; tap k at bits [8k+7:8k], k=3*dy+dx, tap 0 = (row-2,col-2), tap 8 = current pixel.
REQ-013 o_win_row, o_win_col  output  W_SIZE each  output-map coordinate of the window.
REQ-014 o_frame_done  output  1  one-cycle pulse after the last window of a frame.

Function
REQ-015 Pixel cycle = i_data_run=1 and i_end_frame=0; all other cycles shall leave buffers, shift registers and coordinates unchanged.
REQ-016 Two line buffers, each MAX_WIDTH x 8; on each pixel cycle, LB1[col]<=LB0[col], LB0[col]<=i_pixel; the read of index col returns pre-write data.
REQ-017 3x3 shift register: each pixel cycle shifts left one column and loads the new right column {LB1[col], LB0[col], i_pixel}.
REQ-018 States: IDLE, FILL, ACTIVE, DONE.
REQ-019 IDLE->FILL on a pixel cycle with row=0 and col=0 when i_is_conv3x3=1; IDLE->ACTIVE on that cycle when i_is_conv3x3=0; i_is_conv3x3 is latched on that cycle and held until DONE.
REQ-020 FILL->ACTIVE on a pixel cycle with row=2, col=0.
REQ-021 From FILL or ACTIVE, go to DONE on the pixel cycle with row=i_height-1 and col=i_width-1; DONE->IDLE after one cycle; o_frame_done=1 only in DONE.
REQ-022 3x3 mode: o_win_valid=1 exactly one cycle after a pixel cycle with row>=2 and col>=2; o_win_row=row-2 and o_win_col=col-2; output map is (i_width-2)x(i_height-2).
REQ-023 1x1 mode: o_win_valid=1 one cycle after every pixel cycle; tap 8=pixel; taps 0-7=0; o_win_row=row and o_win_col=col.
REQ-024 Latency is fixed at 1 cycle from the pixel cycle to the registered o_win/o_win_valid; there is no backpressure.
REQ-025 Degenerate frame in 3x3 mode (i_width<3 or i_height<3): no windows; o_frame_done still pulses.
REQ-026 Pixels with col>=MAX_WIDTH shall not write the buffers and shall never produce a window.
REQ-027 Outputs hold their last values while o_win_valid=0, except o_frame_done.
REQ-028 A pixel cycle with row=0 and col=0 while in FILL or ACTIVE restarts the frame: state goes to FILL or ACTIVE per REQ-019, with no o_frame_done pulse.

Reset
REQ-029 rstn=0: state IDLE; o_win_valid, o_win, o_win_row, o_win_col and o_frame_done are all 0; shift registers are 0; line-buffer contents are don't-care.
REQ-030 Reset mid-frame aborts the frame; the next frame starts only on a row=0, col=0 pixel cycle.

Configuration
REQ-031 Macro CNN_WIN_CNT_EN defined: add output o_win_count [2*W_SIZE:0], the number of windows emitted this frame; it clears on the frame-start pixel cycle, increments with each o_win_valid, holds through DONE, and resets to 0.
REQ-032 CNN_WIN_CNT_EN undefined: no o_win_count port and no counter logic; all other behaviour is identical.

Verification
REQ-033 3x3 mode, 4x4 frame, pixels 0..15 in raster order -> 4 windows at (0,0),(1,0),(0,1),(1,1); the first window has taps 0,1,2,4,5,6,8,9,10; o_frame_done pulses one cycle after pixel 15.
REQ-034 1x1 mode, 3x2 frame -> 6 windows, each with tap 8 = pixel and other taps 0, 1-cycle latency, coordinates equal to the input coordinates.
REQ-035 3x3 mode, 5x5 frame with upstream hsync gaps (i_data_run=0 for 3 cycles per line) and an i_end_frame cycle -> the 9 windows are unchanged versus a gapless run.
REQ-036 3x3 mode, 2x5 frame -> no o_win_valid; o_frame_done pulses once.
REQ-037 rstn asserted at row 2 of a 4x4 frame, then a full new frame -> outputs are 0 during reset, and the new frame yields exactly 4 correct windows.
REQ-038 With CNN_WIN_CNT_EN, a 6x6 3x3 frame -> o_win_count=16 after DONE and 0 after the next frame start.
